// File: rtl/pp_accumulator_pkg.sv
// Shared constants and state encoding for the Booth partial-product accumulator.
// Build macro PP_ACCUM_DUAL_RATE_EN doubles the partial products reduced per cycle.
package pp_accumulator_pkg;

  localparam int DATA_WIDTH    = 64;
  localparam int PP_WIDTH      = DATA_WIDTH + 1;
  localparam int PRODUCT_WIDTH = 2 * DATA_WIDTH;
  localparam int PP_COUNT      = DATA_WIDTH / 2;

`ifdef PP_ACCUM_DUAL_RATE_EN
  localparam int PP_PER_CYCLE = 8;
`else
  localparam int PP_PER_CYCLE = 4;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DONE    = 2'd3
  } acc_state_t;

endpackage

// File: rtl/pp_accumulator_csa_row.sv
// One 3:2 carry-save compressor row; the carry vector is pre-shifted to its weight.
module csa_row
  import pp_accumulator_pkg::*;
#(
  parameter int WIDTH = PRODUCT_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH-1:0] o_carry
);

  logic [WIDTH-2:0] w_maj;

  assign o_sum = i_a ^ i_b ^ i_c;
  // The majority out of the top bit would land at 2^WIDTH and is dropped.
  assign w_maj = (i_a[WIDTH-2:0] & i_b[WIDTH-2:0]) |
                 (i_a[WIDTH-2:0] & i_c[WIDTH-2:0]) |
                 (i_b[WIDTH-2:0] & i_c[WIDTH-2:0]);
  assign o_carry = {w_maj, 1'b0};

endmodule

// File: rtl/pp_accumulator.sv
// Multi-cycle carry-save reduction of radix-4 Booth partial products to a signed product.
// PP_ACCUM_DUAL_RATE_EN (see package) selects 8 instead of 4 partial products per cycle.
module pp_accumulator
  import pp_accumulator_pkg::*;
(
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              InValid,
  output logic                              InReady,
  input  logic [PP_COUNT*PP_WIDTH-1:0]      PartialProducts,
  input  logic [PP_COUNT-1:0]               NegBits,
  input  logic                              Flush,
  output logic                              OutValid,
  input  logic                              OutReady,
  output logic [PRODUCT_WIDTH-1:0]          Product
);

  localparam int IDX_W = $clog2(PP_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PP_COUNT - PP_PER_CYCLE);
  localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(PP_PER_CYCLE);

  acc_state_t r_state;
  acc_state_t w_state_nxt;

  logic [PP_WIDTH-1:0]      r_pp [PP_COUNT];
  logic [PRODUCT_WIDTH-1:0] r_sum;
  logic [PRODUCT_WIDTH-1:0] r_carry;
  logic [PRODUCT_WIDTH-1:0] r_product;
  logic [IDX_W-1:0]         r_idx;

  logic                     w_accept;
  logic                     w_last;
  logic [PRODUCT_WIDTH-1:0] w_corr;
  logic [PRODUCT_WIDTH-1:0] w_term  [PP_PER_CYCLE];
  logic [PRODUCT_WIDTH-1:0] w_sum   [PP_PER_CYCLE+1];
  logic [PRODUCT_WIDTH-1:0] w_carry [PP_PER_CYCLE+1];

  assign w_accept = (r_state == ST_IDLE) && InValid && !Flush;
  assign w_last   = (r_idx == LAST_IDX);
  assign InReady  = (r_state == ST_IDLE) && !Flush;
  assign OutValid = (r_state == ST_DONE);
  assign Product  = r_product;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_state_nxt = ST_ACCUM;
      ST_ACCUM:   if (w_last)   w_state_nxt = ST_RESOLVE;
      ST_RESOLVE:               w_state_nxt = ST_DONE;
      ST_DONE:    if (OutReady) w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
    if (Flush) w_state_nxt = ST_IDLE;
  end

  // The +1 that completes each ones-complement term sits at that term's weight 2^(2i).
  always_comb begin
    w_corr = '0;
    for (int i = 0; i < PP_COUNT; i++) w_corr[2*i] = NegBits[i];
  end

  always_ff @(posedge Clk) begin
    if (w_accept)
      for (int i = 0; i < PP_COUNT; i++) r_pp[i] <= PartialProducts[PP_WIDTH*i +: PP_WIDTH];
  end

  assign w_sum[0]   = r_sum;
  assign w_carry[0] = r_carry;

  for (genvar j = 0; j < PP_PER_CYCLE; j++) begin : g_row
    logic [IDX_W-1:0]    w_k;
    logic [PP_WIDTH-1:0] w_pp;

    assign w_k  = r_idx + IDX_W'(j);
    assign w_pp = r_pp[w_k];
    assign w_term[j] = {{(PRODUCT_WIDTH-PP_WIDTH){w_pp[PP_WIDTH-1]}}, w_pp} << {w_k, 1'b0};

    csa_row #(.WIDTH(PRODUCT_WIDTH)) u_csa (
      .i_a    (w_sum[j]),
      .i_b    (w_carry[j]),
      .i_c    (w_term[j]),
      .o_sum  (w_sum[j+1]),
      .o_carry(w_carry[j+1])
    );
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_sum     <= '0;
      r_carry   <= '0;
      r_idx     <= '0;
      r_product <= '0;
    end else if (!Flush) begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sum   <= w_corr;
            r_carry <= '0;
            r_idx   <= '0;
          end
        end
        ST_ACCUM: begin
          r_sum   <= w_sum[PP_PER_CYCLE];
          r_carry <= w_carry[PP_PER_CYCLE];
          r_idx   <= r_idx + IDX_STEP;
        end
        ST_RESOLVE: r_product <= r_sum + r_carry;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pp_accumulator.md
# pp_accumulator

Multi-cycle carry-save accumulator for the Balotelli ALU multiplier. It sits directly downstream of the Booth partial-product generator. It consumes 32 radix-4 partial products (65 bits each, in ones-complement form) plus their negation-correction bits, and reduces them over several cycles to a 128-bit signed product. It uses a valid/ready handshake on both sides and holds one operation in flight.

## Interface
- `DATA_WIDTH`, 64: multiplicand/multiplier width. The partial-product width is `DATA_WIDTH+1`.
- `PP_COUNT`, 32: number of partial products (`DATA_WIDTH/2`).
- `PP_PER_CYCLE`, 4: partial products compressed per accumulate cycle. Overridden by the Configuration macro.
- `Clk` (in, 1): the single clock.
- `Rst` (in, 1): reset, asynchronous and active-high.
- `InValid` (in, 1): the partial-product set is valid.
- `InReady` (out, 1): the block is able to accept a set.
- `PartialProducts` (in, 32*65): PP i occupies bits `[65*i+64 : 65*i]` and has weight 2^(2i).
- `NegBits` (in, 32): NegBits[i] = 1 when PP i is a negated (ones-complement) term. It equals bit 2i+1 of the multiplier.
- `Flush` (in, 1): synchronous abort.
- `OutValid` (out, 1): `Product` is valid.
- `OutReady` (in, 1): the consumer accepts `Product`.
- `Product` (out, 128): two's-complement product.

## Operation
- The state machine has four states: IDLE, ACCUM, RESOLVE, DONE.
- **IDLE**
  - `InReady`=1.
  - On `InValid`, register all PPs and `NegBits`.
  - Initialise `SumReg` = correction vector C, where C[2i] = NegBits[i] and all other bits are 0. Initialise `CarryReg` = 0 and `Idx` = 0.
  - Go to ACCUM.
- **ACCUM**
  - Each cycle, sign-extend PPs Idx..Idx+PP_PER_CYCLE-1 to 128 bits (replicate bit 64) and shift each left by 2i.
  - Compress those PPs together with `SumReg` and `CarryReg` using a chain of 3:2 CSA rows. Write the result back to `SumReg`/`CarryReg`.
  - Increment `Idx` by PP_PER_CYCLE.
  - After the cycle that consumes PP 31, go to RESOLVE.
  - All arithmetic is modulo 2^128. Carries out of bit 127 are discarded.
- **RESOLVE**: `Product` = `SumReg` + `CarryReg` (128-bit add, registered). Go to DONE.
- **DONE**
  - `OutValid`=1 and `Product` is stable.
  - On `OutValid`&&`OutReady`, go to IDLE.
  - `InReady`=0 throughout DONE. There is no overlap with the next input.
- **Flush** has priority over everything in every state except IDLE. It moves the block to IDLE on the next edge, deasserts `OutValid`, and discards the partial state.
- **Flush in IDLE**: if `Flush` and `InValid` are both asserted, the input is not accepted.
- `InReady` = (state == IDLE) && !Flush.

## Timing
- **Reset values**: state IDLE, `OutValid`=0, `Product`=0, `SumReg`/`CarryReg`/`Idx`=0. `InReady`=1 after reset deasserts.
- **Reset during operation**: immediate return to IDLE and all outputs take their reset values.
- **Latency** from the acceptance edge (cycle 0):
  - ACCUM occupies cycles 1..8 with PP_PER_CYCLE=4.
  - RESOLVE is cycle 9.
  - `OutValid` rises at cycle 10.
- **Throughput**: one operation every 11 cycles when `OutReady` is held high. The next `InReady` appears in the cycle after the output handshake.
- **Output stalls**: `Product` and `OutValid` are held indefinitely while `OutReady`=0.

## Configuration
- `PP_ACCUM_DUAL_RATE_EN`
  - Defined: PP_PER_CYCLE=8, ACCUM lasts 4 cycles, and `OutValid` rises at cycle 6. The wider CSA chain trades area for speed.
  - Undefined: PP_PER_CYCLE=4 with the 10-cycle latency described above.
- The external handshake behaviour is identical in both builds.

## Structure
- **Shared multiplier package**: `DATA_WIDTH`, `PP_WIDTH`=65, `PRODUCT_WIDTH`=128, `PP_COUNT`, the state encoding typedef, and the `PP_PER_CYCLE` selection under the macro.
- **Sub-module `csa_row`**: a 128-bit 3:2 compressor, instantiated PP_PER_CYCLE times in a chain. Its outputs are sum = a^b^c and carry = majority(a,b,c) shifted left by 1.
- The final adder is inline.

## Test plan
- **Basic latency**: PPs for 3 × 5 → `Product`=15, with `OutValid` exactly 10 cycles after acceptance.
- **Negation corrections**: PPs for -1 × -1 (all ones × all ones) → `Product`=1.
- **Most-negative operands**: 0x8000_0000_0000_0000 × 0x8000_0000_0000_0000 → `Product`=0x4000_0000_0000_0000_0000_0000_0000_0000.
- **Output back-pressure**: hold `OutReady`=0 for 5 cycles after `OutValid`, with `InValid`=1 throughout → `Product` stable, `InReady`=0, and no second acceptance until the cycle after the handshake.
- **Flush mid-operation**: `Flush` at the 4th ACCUM cycle → `OutValid` never asserts and `InReady`=1 on the next cycle. A following 7 × -9 yields -63 (0xFFFF…FFC1).
- **Reset mid-operation**: `Rst` pulsed during RESOLVE → `OutValid`=0 and `Product`=0 immediately. Repeat the latency check with `PP_ACCUM_DUAL_RATE_EN` defined (6 cycles).
